// File: rtl/stopwatch_ctrl.sv
// Control FSM for the 5-digit BCD stopwatch: button sequencing, tick prescaler,
// saturation at MAX_COUNT and lap-freeze display selection.
`timescale 1ns/1ps
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV  = 5000000,
  parameter int unsigned DIV_W     = 23,
  parameter logic [19:0] MAX_COUNT = 20'h59599
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_stop,
  input  logic        lap,
  input  logic        clear,
  input  logic [19:0] digits,
  output logic        cnt_inc,
  output logic        cnt_reset,
  output logic [19:0] disp_digits,
  output logic        running,
  output logic        full
);

  typedef enum logic [2:0] {IDLE, RUN, LAP, STOP, FULL} state_t;

  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(TICK_DIV - 1);

  state_t           state, state_nxt;
  logic [DIV_W-1:0] presc, presc_nxt;
  logic [19:0]      lap_reg;
  logic             lap_load;
  logic             inc_nxt;
  logic             rst_nxt;
  logic             counting;
  logic             wrap;

  function automatic logic at_max(input logic [19:0] d);
    return d == MAX_COUNT;
  endfunction

  function automatic logic [DIV_W-1:0] presc_step(input logic [DIV_W-1:0] p);
    return (p == PRESC_LAST) ? '0 : p + DIV_W'(1);
  endfunction

  assign counting = (state == RUN) || (state == LAP);
  assign wrap     = counting && (presc == PRESC_LAST);

  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    lap_load  = 1'b0;
    inc_nxt   = 1'b0;
    rst_nxt   = 1'b0;
    case (state)
      IDLE: begin
        presc_nxt = '0;
        if (clear)           rst_nxt   = 1'b1;
        else if (start_stop) state_nxt = RUN;
      end
      RUN: begin
        presc_nxt = presc_step(presc);
        if (start_stop) state_nxt = STOP;
        else if (lap) begin
          state_nxt = LAP;
          lap_load  = 1'b1;
        end
      end
      LAP: begin
        presc_nxt = presc_step(presc);
        if (start_stop) state_nxt = STOP;
        else if (lap)   state_nxt = RUN;
      end
      STOP: begin
        if (clear) begin
          state_nxt = IDLE;
          rst_nxt   = 1'b1;
          presc_nxt = '0;
        end else if (start_stop) begin
          state_nxt = RUN;
        end
      end
      FULL: begin
        if (clear) begin
          state_nxt = IDLE;
          rst_nxt   = 1'b1;
          presc_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Saturation at the wrap overrides any button decision taken on the same edge.
    if (wrap) begin
      if (at_max(digits)) begin
        state_nxt = FULL;
        lap_load  = 1'b0;
      end else begin
        inc_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      presc     <= '0;
      lap_reg   <= '0;
      cnt_inc   <= 1'b0;
      cnt_reset <= 1'b1;
    end else begin
      state     <= state_nxt;
      presc     <= presc_nxt;
      cnt_inc   <= inc_nxt;
      cnt_reset <= rst_nxt;
      if (lap_load) lap_reg <= digits;
    end
  end

  assign disp_digits = (state == LAP) ? lap_reg : digits;
  assign running     = counting;
  assign full        = (state == FULL);

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM that sequences the 5-digit BCD stopwatch counter (MM:SS.t, tenths digit in bits 3:0).
- Converts single-cycle start/stop, lap and clear button pulses into counter control.
- Prescales the system clock into counter increment ticks and saturates at 59:59.9.
- Holds a lap snapshot and selects live or frozen digits for the display driver.

Parameters:
TICK_DIV, 5000000, clk cycles per counter increment (50 MHz -> 0.1 s); legal range >= 2
DIV_W, 23, prescaler width; must satisfy 2**DIV_W >= TICK_DIV
MAX_COUNT, 20'h59599, BCD value at which counting saturates (59:59.9)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start_stop  input  1  single-cycle debounced pulse: toggle run/pause
lap  input  1  single-cycle debounced pulse: capture/release lap display
clear  input  1  single-cycle debounced pulse: zero the counter
digits  input  20  live counter value, 5 BCD nibbles
cnt_inc  output  1  one-cycle increment strobe to counter LSD
cnt_reset  output  1  synchronous clear to counter (active-high)
disp_digits  output  20  digits for display: lap register in LAP, else live digits
running  output  1  high in RUN and LAP
full  output  1  high in FULL

Behaviour:
- Reset values: state=IDLE, prescaler=0, lap register=0, cnt_inc=0, cnt_reset=1. cnt_reset drops to 0 on the first clk edge after reset deasserts, so the counter is cleared at power-up.
- States: IDLE (zeroed, stopped), RUN, LAP (running, display frozen), STOP (paused), FULL (saturated).
- Simultaneous inputs, priority clear > start_stop > lap; only the highest-priority input that is legal in the current state acts. The rest are dropped.
- IDLE:
  - start_stop -> RUN.
  - clear -> stay IDLE, cnt_reset pulse.
  - lap ignored.
- RUN:
  - start_stop -> STOP.
  - lap -> LAP; the lap register loads the digits value sampled on that edge.
  - clear ignored.
- LAP:
  - start_stop -> STOP (freeze released).
  - lap -> RUN (freeze released).
  - clear ignored.
- STOP:
  - start_stop -> RUN.
  - clear -> IDLE with cnt_reset pulse, prescaler <= 0.
  - lap ignored.
- FULL:
  - clear -> IDLE with cnt_reset pulse, prescaler <= 0.
  - All other inputs ignored.
- cnt_reset is a registered one-cycle pulse asserted in the cycle after the clear edge.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN/LAP and wraps to 0.
  - Holds its value in STOP, so resume keeps sub-tick phase.
  - Is 0 in IDLE.
- cnt_inc (registered, 1 cycle) fires when the prescaler wraps in RUN/LAP and digits != MAX_COUNT.
  - If digits == MAX_COUNT at the wrap: no cnt_inc; state -> FULL on that edge.
  - A start_stop or lap pulse on the same edge as the wrap still changes state; the tick decision uses the pre-edge state.
- Latency:
  - A start_stop pulse at edge N gives state RUN at N+1.
  - From IDLE, the first cnt_inc is high in the cycle after edge N+TICK_DIV.
- disp_digits is combinational: the lap register in LAP, else digits. running and full decode from state.
- Asynchronous reset mid-operation returns every register to its reset value immediately, including from LAP and FULL.

Test Plan:
- TICK_DIV=4; reset, release -> cnt_reset=1 for first cycle then 0. Start_stop pulse -> cnt_inc every 4th cycle, first 4 cycles after RUN entry; running=1.
- RUN, counter at 00:03.2, lap pulse -> disp_digits holds 20'h00032 while cnt_inc continues. Second lap pulse -> disp_digits follows live digits, state RUN.
- RUN, prescaler=2, start_stop -> no cnt_inc while paused. Start_stop again -> next cnt_inc after exactly 2 cycles (phase kept).
- clear during RUN -> ignored, no cnt_reset. start_stop then clear same cycle in STOP -> clear wins: cnt_reset one-cycle pulse, state IDLE.
- digits forced to 20'h59599 in RUN -> at wrap no cnt_inc, full=1, running=0. start_stop/lap ignored; clear -> IDLE with cnt_reset.
- Assert reset (low) while in LAP -> immediately state IDLE, lap register 0, cnt_inc=0, cnt_reset=1.
